// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, in-order imem requests, a response
// FIFO feeding decode, redirect flush of stale responses and a sticky halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nxt;

    logic [31:0]   req_pc, resp_pc;
    logic [CW-1:0] occ, live, drop, stale;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_ins [DEPTH];
    logic [31:0]   fifo_pc  [DEPTH];

    logic        run, pop, accept, rsp_keep, rsp_drop, flush;
    logic [31:0] target;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Halt is sticky; only reset leaves HALTED
    always_comb begin
        state_nxt = state;
        if (state == RUN && halt) state_nxt = HALTED;
    end

    assign run       = rst_n && (state == RUN);
    assign ins_valid = run && (occ != '0);
    assign pop       = ins_valid && ins_ready;
    assign imem_req  = run && !halt && !redirect_valid && ((occ + live - CW'(pop)) < DEPTH_C);
    assign imem_addr = rst_n ? req_pc : RESET_PC;
    assign ins       = rst_n ? fifo_ins[rd_ptr] : '0;
    assign ins_pc    = rst_n ? fifo_pc[rd_ptr]  : '0;

    assign accept   = imem_req && imem_ready;
    assign rsp_drop = imem_rvalid && (drop != '0);
    assign rsp_keep = run && imem_rvalid && (drop == '0) && (live != '0);
    assign flush    = run && (halt || redirect_valid);
    assign target   = redirect_pc & ~32'h3;
    // A response arriving in the flush cycle is already stale, so it nets out here
    assign stale    = drop + live - CW'(rsp_drop || rsp_keep);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc  <= RESET_PC;
            resp_pc <= RESET_PC;
            occ     <= '0;
            live    <= '0;
            drop    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (flush) begin
            occ    <= '0;
            live   <= '0;
            drop   <= stale;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if (!halt) begin
                req_pc  <= target;
                resp_pc <= target;
            end
        end else begin
            occ  <= occ + CW'(rsp_keep) - CW'(pop);
            live <= live + CW'(accept) - CW'(rsp_keep);
            drop <= drop - CW'(rsp_drop);
            if (accept)   req_pc <= req_pc + 32'd4;
            if (rsp_keep) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage needs no reset; occupancy qualifies it
    always_ff @(posedge clk) begin
        if (rsp_keep && !flush) begin
            fifo_ins[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]  <= resp_pc;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(rsp_keep && !flush && occ == DEPTH_C));
            assert (!(imem_rvalid && live == '0 && drop == '0));
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit: memory model plus an
// expected-instruction scoreboard checked by an independent monitor.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       mem_q[$];
    logic [31:0] seen_pc[$];
    exp_t        e;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] last_acc_addr = '0;
    bit          halted_m = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          pop_cnt = 0;
    int          acc_cnt = 0;
    int          first_acc = -1;
    int          first_valid = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every decoder handshake must match the head of the expected stream
    always @(negedge clk) begin
        if (rst_n && ins_valid && ins_ready) begin
            pop_cnt++;
            seen_pc.push_back(ins_pc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ins_unexpected: got pc=%h ins=%h expected no instruction", ins_pc, ins);
            end else begin
                e = exp_q.pop_front();
                if (ins_pc !== e.pc || ins !== e.ins) begin
                    errors++;
                    $display("FAIL ins_stream: got pc=%h ins=%h expected pc=%h ins=%h",
                             ins_pc, ins, e.pc, e.ins);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        mem_q.delete(); exp_q.delete(); seen_pc.delete();
        model_pc = RESET_PC; halted_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            check("reset_req", 32'(imem_req), 32'd0);
            check("reset_valid", 32'(ins_valid), 32'd0);
            check("reset_ins", ins, 32'd0);
            check("reset_ins_pc", ins_pc, 32'd0);
            check("reset_addr", imem_addr, RESET_PC);
            @(posedge clk); #1;
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    // One clock cycle: memory presents due response, inputs applied, model updated
    task automatic step(input bit rdy, input bit ir, input bit redir, input logic [31:0] rpc,
                        input bit hlt, input int lat);
        bit was_halted;
        bit acc;
        was_halted = halted_m;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_ready = rdy; ins_ready = ir; redirect_valid = redir; redirect_pc = rpc; halt = hlt;
        @(negedge clk); #1;
        acc = imem_req && imem_ready;
        if (was_halted) begin
            check("halted_req", 32'(imem_req), 32'd0);
            check("halted_valid", 32'(ins_valid), 32'd0);
        end
        if (redir || hlt) check("req_in_flush_cycle", 32'(imem_req), 32'd0);
        if (ins_valid && first_valid < 0) first_valid = cyc;
        if (acc) begin
            check("imem_addr", imem_addr, model_pc);
            if (first_acc < 0) first_acc = cyc;
            acc_cnt++;
            last_acc_addr = imem_addr;
            mem_q.push_back('{imem_addr, cyc + lat});
            exp_q.push_back('{imem_addr, imem_addr ^ KEY});
            model_pc = model_pc + 32'd4;
        end
        if (!halted_m && hlt) begin
            halted_m = 1'b1;
            exp_q.delete();
        end else if (!halted_m && redir) begin
            exp_q.delete();
            seen_pc.delete();
            model_pc = rpc & ~32'h3;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bit bad;

        // Streaming with 1-cycle memory: latency 2 and one instruction per cycle
        do_reset(2);
        first_acc = -1; first_valid = -1; pop_cnt = 0;
        repeat (24) step(1, 1, 0, '0, 0, 1);
        check("first_latency", 32'(first_valid - first_acc), 32'd2);
        check("throughput", 32'(pop_cnt), 32'd22);

        // Stalled decoder: exactly DEPTH words fetched, head held, then no gap
        do_reset(1);
        acc_cnt = 0;
        repeat (10) step(1, 0, 0, '0, 0, 1);
        check("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_head_pc", ins_pc, 32'h0);
        check("stall_head_ins", ins, 32'h0 ^ KEY);
        pop_cnt = 0;
        repeat (20) step(1, 1, 0, '0, 0, 1);
        check("release_pops", 32'(pop_cnt), 32'd20);

        // Redirect with 0x8/0xC outstanding on a 3-cycle memory
        do_reset(1);
        repeat (4) step(1, 1, 0, '0, 0, 3);
        step(0, 1, 0, '0, 0, 3);
        step(0, 1, 1, 32'h100, 0, 3);
        repeat (12) step(1, 1, 0, '0, 0, 1);
        check("redir_seen", 32'(seen_pc.size() > 0), 32'd1);
        if (seen_pc.size() > 0) check("redir_first_pc", seen_pc[0], 32'h100);
        bad = 1'b0;
        foreach (seen_pc[i]) if (seen_pc[i] == 32'h8 || seen_pc[i] == 32'hC) bad = 1'b1;
        check("redir_stale_seen", 32'(bad), 32'd0);

        // Redirect coinciding with a response and a pop; target low bits ignored
        do_reset(1);
        repeat (6) step(1, 1, 0, '0, 0, 1);
        step(1, 1, 1, 32'h202, 0, 1);
        step(1, 1, 0, '0, 0, 1);
        check("redir_next_addr", last_acc_addr, 32'h200);
        repeat (6) step(1, 1, 0, '0, 0, 1);
        if (seen_pc.size() > 0) check("redir2_first_pc", seen_pc[0], 32'h200);
        else check("redir2_seen", 32'd0, 32'd1);

        // Halt with two buffered words and one in flight; later redirect ignored
        do_reset(1);
        step(1, 0, 0, '0, 0, 1);
        step(1, 0, 0, '0, 0, 1);
        step(1, 0, 0, '0, 0, 3);
        step(0, 0, 0, '0, 0, 1);
        check("pre_halt_valid", 32'(ins_valid), 32'd1);
        step(0, 0, 0, '0, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 1, (i == 3), 32'h40, 0, 1);
        do_reset(1);
        #1;
        check("halt_restart_req", 32'(imem_req), 32'd1);
        check("halt_restart_addr", imem_addr, RESET_PC);

        // One-cycle reset with a full FIFO
        repeat (8) step(1, 0, 0, '0, 0, 1);
        check("full_valid", 32'(ins_valid), 32'd1);
        do_reset(1);
        #1;
        check("rst_restart_req", 32'(imem_req), 32'd1);
        check("rst_restart_addr", imem_addr, RESET_PC);
        repeat (6) step(1, 1, 0, '0, 0, 1);
        if (seen_pc.size() > 0) check("rst_first_pc", seen_pc[0], RESET_PC);
        else check("rst_seen", 32'd0, 32'd1);

        // Randomized traffic, then drain and confirm nothing was lost
        for (int r = 0; r < 3; r++) begin
            do_reset(1);
            for (int i = 0; i < 300; i++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 24) == 0, $urandom & 32'h0000_0FFF, 0,
                     int'($urandom_range(1, 3)));
            repeat (12) step(0, 1, 0, '0, 0, 1);
            check("drain_left", 32'(exp_q.size()), 32'd0);
            step(1, 1, 0, '0, 1, 1);
            repeat (4) step(1, 1, 1, 32'h80, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the 32-bit instruction word consumed by the decoder, together with its PC.
- Keeps a PC register and issues in-order word requests to instruction memory over a req/ready request channel and a separate rvalid response channel.
- Buffers responses in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Supports branch/jump redirect with flush of stale responses, and a sticky halt.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, instruction FIFO entries (power of 2, >=2); also the cap on buffered-plus-in-flight words

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address, bits [1:0] always 0
imem_ready  in  1  memory accepts request when imem_req && imem_ready
imem_rvalid  in  1  response word valid; responses in request order, >=1 cycle after acceptance
imem_rdata  in  32  response instruction word
ins_valid  out  1  instruction available to decoder
ins  out  32  instruction word (FIFO head)
ins_pc  out  32  byte address of ins
ins_ready  in  1  decoder consumes when ins_valid && ins_ready
redirect_valid  in  1  one-cycle pulse: taken branch/jump
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
halt  in  1  halt request from decode (is_halt), sticky once seen

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - req_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, live=0, drop=0, state RUN.
  - Outputs while in reset: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0.
  - Reset mid-operation discards all state. The memory is reset in the same cycle, so no responses arrive after reset.
- States: RUN, HALTED. RUN->HALTED when halt=1. HALTED is left only by reset.
- Counters:
  - live = requests accepted whose response is still to be kept.
  - drop = requests accepted whose response must be discarded.
  - occ = FIFO occupancy.
  - All counters are log2(DEPTH)+1 bits.
- Issue rule: imem_req = (state==RUN) && !halt && !redirect_valid && (occ + live - pop < DEPTH), where pop = ins_valid && ins_ready.
  - imem_addr = req_pc.
  - On acceptance: req_pc += 4 (wraps modulo 2^32) and live += 1.
- Response: on imem_rvalid:
  - If drop>0: drop -= 1, word discarded.
  - Else: push {imem_rdata, resp_pc}, resp_pc += 4, live -= 1.
  - Accept, response and pop may all occur in the same cycle; the counters net correctly.
- Latency: request accepted in cycle N, rvalid in N+1 -> ins_valid in N+2. Throughput is 1 instruction/cycle with 1-cycle memory and ins_ready=1.
- Output: ins/ins_pc are driven from the FIFO head and held stable while ins_valid && !ins_ready. ins_valid = (occ!=0) && state==RUN.
- Redirect (redirect_valid=1, state RUN, halt=0), effective at the clock edge:
  - FIFO cleared; a same-cycle pop is ignored.
  - drop = drop + live, minus 1 if a response arrives in that cycle (that response counts as stale). live=0.
  - req_pc = resp_pc = {redirect_pc[31:2],2'b00}.
  - imem_req is 0 during the redirect cycle. Fetch resumes the next cycle, even while drop>0.
- Halt: halt=1 has priority over a same-cycle redirect.
  - Next cycle: state HALTED, imem_req=0, ins_valid=0, FIFO cleared.
  - Outstanding responses are absorbed, not pushed.
  - redirect_valid is ignored in HALTED.
- FIFO full with rvalid cannot occur: the issue rule guarantees space. A push to a full FIFO is a design error and gets a simulation assertion.
- Empty FIFO with ins_ready=1: no pop, ins_valid=0.
- imem_rvalid while live=0 && drop=0: protocol error, response ignored, assertion fires.

Test Plan:
1. Release reset; 1-cycle memory returning rdata=addr^32'hA5A5_0000; ins_ready=1 -> ins_pc 0,4,8,... consecutive cycles; first ins_valid 2 cycles after first acceptance; ins=ins_pc^32'hA5A5_0000.
2. ins_ready=0 from start -> exactly DEPTH=4 words accepted, then imem_req=0; ins/ins_pc held at 0; raise ins_ready -> 0,4,8,12,16,... with no gap, duplicate or loss.
3. Memory latency 3, two requests in flight (0x8,0xC), redirect_pc=0x100 -> both stale responses dropped; next ins_pc=0x100; no ins_pc 0x8/0xC observed.
4. Redirect same cycle as rvalid and a pop, redirect_pc=0x202 -> imem_addr 0x200 next cycle; that rvalid word never appears; first ins_pc=0x200.
5. Halt pulse with 2 FIFO entries and 1 in flight -> next cycle imem_req=0, ins_valid=0; later rvalid and redirect ignored; stays halted until rst_n=0, then fetch restarts at RESET_PC.
6. rst_n=0 for one cycle with FIFO full -> following cycle ins_valid=0, imem_req=0; first request after release at imem_addr=RESET_PC.
